hack_rom_sequencer: RTL and testbench
=====================================

HACK_ROM_SEQUENCER -- requirements
Module: hack_rom_sequencer

Interface
REQ-001 The module SHALL have parameter RESET_HOLD, default 4: number of cycles cpu_reset stays asserted after a run command (legal range 1..255).
REQ-002 The module SHALL have parameter ROM_DEPTH, default 256: number of implemented ROM words.
REQ-003 CLK  in  1  single system clock; all state updates on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 host_req  in  1  shell transaction request, held high until host_ack.
REQ-006 host_we  in  1  1 = write, 0 = read; sampled with host_req.
REQ-007 host_addr  in  16  shell ROM word address.
REQ-008 host_wdata  in  16  shell write data.
REQ-009 host_ack  out  1  one-cycle transaction-complete pulse.
REQ-010 host_rdata  out  16  read data, valid while host_ack=1.
REQ-011 run_cmd  in  1  level; request to start the CPU.
REQ-012 halt_cmd  in  1  level; request to stop the CPU and return ROM ownership to the shell.
REQ-013 cpu_pc  in  16  CPU fetch address.
REQ-014 cpu_inst  out  16  registered instruction to the CPU.
REQ-015 cpu_reset  out  1  active-high CPU reset.
REQ-016 rom_addr  out  16  ROM shared address; rom_wdata  out  16; rom_we  out  1.
REQ-017 rom_rdata  in  16  ROM read data, valid one cycle after rom_addr is presented.
REQ-018 mode  out  2  current state encoding; busy  out  1  shell transaction in flight.

Function
REQ-019 The FSM SHALL have three states: BOOT=2'd0 (shell owns ROM), HOLD=2'd1 (CPU held in reset), RUN=2'd2 (CPU owns ROM); mode SHALL equal the state.
REQ-020 In BOOT, an access SHALL be accepted when host_req=1, busy=0 and host_ack=0.
REQ-021 In the acceptance cycle T, the block SHALL drive rom_addr=host_addr and rom_wdata=host_wdata, and SHALL assert rom_we=host_we for exactly that cycle.
REQ-022 busy SHALL be 1 from T+1 until host_ack.
REQ-023 host_ack SHALL pulse at T+2.
REQ-024 On a read, host_rdata SHALL be rom_rdata captured at T+1.
REQ-025 On a write, host_rdata SHALL be 16'h0000.
REQ-026 If host_addr >= ROM_DEPTH, rom_we SHALL stay 0, host_ack SHALL still pulse at T+2, and host_rdata SHALL be 16'h0000.
REQ-027 Back-to-back accesses SHALL have a minimum spacing of 3 cycles, because acceptance is blocked while host_ack=1.
REQ-028 The block SHALL move BOOT->HOLD on run_cmd=1 with halt_cmd=0 and busy=0.
REQ-029 A run_cmd arriving with busy=1 SHALL be acted on only after host_ack, once the in-flight transaction completes.
REQ-030 In HOLD, cpu_reset SHALL be 1, rom_addr SHALL be 16'h0000 and cpu_inst SHALL be 16'h0000.
REQ-031 The HOLD counter SHALL count RESET_HOLD cycles, then the FSM SHALL move to RUN.
REQ-032 In RUN, cpu_reset SHALL be 0, rom_addr SHALL be cpu_pc, rom_we SHALL be 0, and cpu_inst SHALL be registered rom_rdata (2-cycle pc-to-instruction latency).
REQ-033 In RUN, host_req SHALL be ignored: no ack is given and the request stays pending.
REQ-034 halt_cmd=1 in HOLD or RUN SHALL move the FSM to BOOT next cycle, with cpu_reset=1 and cpu_inst=16'h0000 in that BOOT cycle.
REQ-035 When run_cmd and halt_cmd are asserted together, halt_cmd SHALL win in every state.
REQ-036 In BOOT, cpu_reset SHALL be 1 and cpu_inst SHALL be 16'h0000.
REQ-037 When no access is accepted in BOOT, rom_addr SHALL hold its last value and rom_we SHALL be 0.
REQ-038 run_cmd held high SHALL NOT retrigger HOLD while in RUN; it is level-sensitive only in BOOT.

Reset
REQ-039 RST_N=0 SHALL immediately force state=BOOT, cpu_reset=1, host_ack=0, busy=0, rom_we=0, rom_addr=0, rom_wdata=0, host_rdata=0, cpu_inst=0 and HOLD counter=0.
REQ-040 A transaction interrupted by reset SHALL be aborted with no ack, and any partial write SHALL be discarded as far as the block is concerned.
REQ-041 Reset release SHALL be synchronised so that the first FSM transition occurs no earlier than the second CLK edge after RST_N rises.

Verification
REQ-042 The bench SHALL cover: write 16'hBEEF to addr 5 at T, then read addr 5 -> rom_we=1 only at T, ack at T+2, read ack returns host_rdata=16'hBEEF.
REQ-043 The bench SHALL cover: write to addr 300 with ROM_DEPTH=256 -> rom_we stays 0, ack at T+2, host_rdata=0.
REQ-044 The bench SHALL cover: run_cmd during busy read -> ack first, then HOLD for exactly 4 cycles with cpu_reset=1, then RUN with cpu_reset=0.
REQ-045 The bench SHALL cover: in RUN, cpu_pc=3 with ROM[3]=16'h1234 -> cpu_inst=16'h1234 two cycles later; a host_req raised in RUN gets no ack until after halt.
REQ-046 The bench SHALL cover: run_cmd=1 and halt_cmd=1 asserted together in BOOT and in RUN -> FSM stays in or returns to BOOT, cpu_reset=1.
REQ-047 The bench SHALL cover: RST_N pulsed low mid-read and mid-HOLD -> all outputs reach their reset values without a clock edge, and no ack is issued.

Source files
------------

// File: rtl/hack_rom_sequencer.sv
// ROM ownership sequencer for a Hack-style CPU.
// In BOOT the shell host reads and writes the shared ROM one word at a time.
// A run command holds the CPU in reset for RESET_HOLD cycles and then hands
// the ROM address bus to the CPU fetch port. A halt command returns the ROM
// to the shell and puts the CPU back into reset.
module hack_rom_sequencer #(
  parameter int RESET_HOLD = 4,   // 1..255
  parameter int ROM_DEPTH  = 256
) (
  input  logic        CLK,
  input  logic        RST_N,
  // shell host port
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  // run control
  input  logic        run_cmd,
  input  logic        halt_cmd,
  // CPU side
  input  logic [15:0] cpu_pc,
  output logic [15:0] cpu_inst,
  output logic        cpu_reset,
  // shared ROM port
  output logic [15:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        rom_we,
  input  logic [15:0] rom_rdata,
  // status
  output logic [1:0]  mode,
  output logic        busy
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [7:0]  HOLD_LAST = 8'(RESET_HOLD - 1);
  localparam logic [16:0] ROM_LIMIT = 17'(ROM_DEPTH);

  state_e      state_q, state_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]  rst_sync_q;
  logic        busy_q;      // access accepted last cycle, ROM data arrives now
  logic        rd_q;        // that access is an in-range read
  logic        ack_q;
  logic [15:0] rdata_q;
  logic [15:0] rom_addr_q;
  logic [15:0] rom_wdata_q;
  logic [15:0] cpu_inst_q;

  logic        active;
  logic        accept;
  logic        in_range;

  // The FSM is allowed to act only once reset release has crossed two flops;
  // reset assertion still clears everything immediately.
  assign active   = rst_sync_q[1];
  assign in_range = ({1'b0, host_addr} < ROM_LIMIT);

  // Reset release synchroniser.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync_q <= 2'b00;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // Next-state logic, HOLD counter and shell access acceptance.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    accept     = 1'b0;
    case (state_q)
      BOOT: begin
        if (active) begin
          if (run_cmd && !halt_cmd && !busy_q) begin
            state_d    = HOLD;
            hold_cnt_d = 8'd0;
          end else if (host_req && !busy_q && !ack_q) begin
            accept = 1'b1;
          end
        end
      end
      HOLD: begin
        if (halt_cmd) begin
          state_d    = BOOT;
          hold_cnt_d = 8'd0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = 8'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      RUN: begin
        if (halt_cmd) begin
          state_d = BOOT;
        end
      end
      default: begin
        state_d    = BOOT;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  // ROM port mux: shell access, forced zero address, or CPU fetch address.
  always_comb begin
    rom_addr  = rom_addr_q;
    rom_wdata = rom_wdata_q;
    rom_we    = 1'b0;
    case (state_q)
      BOOT: begin
        if (accept) begin
          rom_addr  = host_addr;
          rom_wdata = host_wdata;
          rom_we    = host_we && in_range;
        end
      end
      HOLD:    rom_addr = 16'h0000;
      RUN:     rom_addr = cpu_pc;
      default: rom_addr = rom_addr_q;
    endcase
  end

  // State and HOLD counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= BOOT;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Shell transaction pipeline, held ROM bus values and CPU instruction register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= 16'h0000;
      rom_addr_q  <= 16'h0000;
      rom_wdata_q <= 16'h0000;
      cpu_inst_q  <= 16'h0000;
    end else begin
      busy_q      <= accept;
      rd_q        <= accept && !host_we && in_range;
      ack_q       <= busy_q;
      if (busy_q) begin
        rdata_q <= rd_q ? rom_rdata : 16'h0000;
      end
      rom_addr_q  <= rom_addr;
      rom_wdata_q <= rom_wdata;
      // Instruction is only valid while RUN persists; leaving RUN clears it.
      cpu_inst_q  <= (state_q == RUN && state_d == RUN) ? rom_rdata : 16'h0000;
    end
  end

  assign host_ack   = ack_q;
  assign host_rdata = rdata_q;
  assign busy       = busy_q;
  assign mode       = state_q;
  assign cpu_reset  = (state_q != RUN);
  assign cpu_inst   = cpu_inst_q;

endmodule

// File: tb/tb_hack_rom_sequencer.sv
// Directed bench for hack_rom_sequencer with a scoreboard on the host ack port
// and a synchronous ROM model on the shared ROM port.
module tb_hack_rom_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        host_req, host_we;
  logic [15:0] host_addr, host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        run_cmd, halt_cmd;
  logic [15:0] cpu_pc;
  logic [15:0] cpu_inst;
  logic        cpu_reset;
  logic [15:0] rom_addr, rom_wdata;
  logic        rom_we;
  logic [15:0] rom_rdata;
  logic [1:0]  mode;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem [256];

  hack_rom_sequencer #(.RESET_HOLD(4), .ROM_DEPTH(256)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .run_cmd(run_cmd), .halt_cmd(halt_cmd),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_reset(cpu_reset),
    .rom_addr(rom_addr), .rom_wdata(rom_wdata), .rom_we(rom_we),
    .rom_rdata(rom_rdata), .mode(mode), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: data for the address presented in one cycle appears in the next.
  always @(posedge CLK) begin
    if (rom_we) mem[rom_addr[7:0]] <= rom_wdata;
    rom_rdata <= mem[rom_addr[7:0]];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack is matched against the oldest expected read data.
  initial begin
    forever begin
      @(negedge CLK);
      if (host_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with rdata %h, none expected at %0t", host_rdata, $time);
        end else begin
          check("ack_rdata", host_rdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mode"},      {14'd0, mode}, 16'd0);
    check({tag, "_cpu_reset"}, {15'd0, cpu_reset}, 16'd1);
    check({tag, "_ack"},       {15'd0, host_ack}, 16'd0);
    check({tag, "_busy"},      {15'd0, busy}, 16'd0);
    check({tag, "_rom_we"},    {15'd0, rom_we}, 16'd0);
    check({tag, "_rom_addr"},  rom_addr, 16'h0000);
    check({tag, "_rom_wdata"}, rom_wdata, 16'h0000);
    check({tag, "_rdata"},     host_rdata, 16'h0000);
    check({tag, "_cpu_inst"},  cpu_inst, 16'h0000);
  endtask

  // One shell access starting at the next negedge (cycle T); ack expected at T+2.
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] rdata_exp, input logic we_exp);
    @(negedge CLK);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    exp_q.push_back(rdata_exp);
    #1;
    check("rom_we_T",   {15'd0, rom_we}, {15'd0, we_exp});
    check("rom_addr_T", rom_addr, addr);
    if (we) check("rom_wdata_T", rom_wdata, wdata);
    @(negedge CLK);
    check("busy_T1",   {15'd0, busy}, 16'd1);
    check("rom_we_T1", {15'd0, rom_we}, 16'd0);
    check("ack_T1",    {15'd0, host_ack}, 16'd0);
    @(negedge CLK);
    check("ack_T2",  {15'd0, host_ack}, 16'd1);
    check("busy_T2", {15'd0, busy}, 16'd0);
    host_req = 1'b0;
  endtask

  task automatic wait_mode(input logic [1:0] m, input string name);
    int n = 0;
    while (mode !== m && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check(name, {14'd0, mode}, {14'd0, m});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    run_cmd = 1'b0; halt_cmd = 1'b0; cpu_pc = '0;
    #2;
    check_reset_outputs("por");
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Shell writes and reads, back to back at minimum spacing.
    access(1'b1, 16'd5,  16'hBEEF, 16'h0000, 1'b1);
    access(1'b1, 16'd3,  16'h1234, 16'h0000, 1'b1);
    access(1'b1, 16'd44, 16'hA5A5, 16'h0000, 1'b1);
    access(1'b0, 16'd5,  16'h0000, 16'hBEEF, 1'b0);
    // Out of range: 300 aliases to model word 44 but must neither write nor return data.
    access(1'b1, 16'd300, 16'h1111, 16'h0000, 1'b0);
    access(1'b0, 16'd300, 16'h0000, 16'h0000, 1'b0);
    access(1'b0, 16'd44,  16'h0000, 16'hA5A5, 1'b0);

    // run_cmd arriving while a read is in flight.
    @(negedge CLK);
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd5;
    exp_q.push_back(16'hBEEF);
    @(negedge CLK);
    run_cmd = 1'b1;
    check("run_busy_busy", {15'd0, busy}, 16'd1);
    check("run_busy_mode", {14'd0, mode}, 16'd0);
    @(negedge CLK);
    check("run_busy_ack",  {15'd0, host_ack}, 16'd1);
    check("run_busy_mode2", {14'd0, mode}, 16'd0);
    host_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("hold_mode",      {14'd0, mode}, 16'd1);
      check("hold_cpu_reset", {15'd0, cpu_reset}, 16'd1);
      check("hold_rom_addr",  rom_addr, 16'h0000);
      check("hold_cpu_inst",  cpu_inst, 16'h0000);
    end
    @(negedge CLK);
    check("run_mode",      {14'd0, mode}, 16'd2);
    check("run_cpu_reset", {15'd0, cpu_reset}, 16'd0);

    // Fetch from pc 3, instruction two cycles later.
    cpu_pc = 16'd3;
    #1;
    check("run_rom_addr", rom_addr, 16'd3);
    check("run_rom_we",   {15'd0, rom_we}, 16'd0);
    @(negedge CLK);
    @(negedge CLK);
    check("run_cpu_inst", cpu_inst, 16'h1234);

    // Host request in RUN stays pending; run_cmd held high does not retrigger HOLD.
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd3;
    exp_q.push_back(16'h1234);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("run_no_ack",  {15'd0, host_ack}, 16'd0);
      check("run_stay",    {14'd0, mode}, 16'd2);
    end
    // run and halt together in RUN: halt wins.
    halt_cmd = 1'b1;
    @(negedge CLK);
    check("halt_mode",      {14'd0, mode}, 16'd0);
    check("halt_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    check("halt_cpu_inst",  cpu_inst, 16'h0000);
    @(negedge CLK);
    check("pending_busy", {15'd0, busy}, 16'd1);
    @(negedge CLK);
    check("pending_ack",  {15'd0, host_ack}, 16'd1);
    host_req = 1'b0;
    // run and halt together in BOOT: stay in BOOT.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("both_boot_mode",  {14'd0, mode}, 16'd0);
      check("both_boot_reset", {15'd0, cpu_reset}, 16'd1);
    end
    run_cmd = 1'b0; halt_cmd = 1'b0;

    // Reset pulsed in the middle of a read: no ack afterwards.
    @(negedge CLK);
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd5;
    @(negedge CLK);
    check("mid_read_busy", {15'd0, busy}, 16'd1);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("rst_read");
    host_req = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("post_rst_no_ack", {15'd0, host_ack}, 16'd0);
    end

    // Reset pulsed in the middle of HOLD.
    run_cmd = 1'b1;
    wait_mode(2'd1, "enter_hold");
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("rst_hold");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_sync_mode", {14'd0, mode}, 16'd0);
    wait_mode(2'd1, "reenter_hold");
    halt_cmd = 1'b1; run_cmd = 1'b0;
    @(negedge CLK);
    check("halt_hold_mode", {14'd0, mode}, 16'd0);
    halt_cmd = 1'b0;

    // Shell still works after all of that.
    access(1'b0, 16'd5, 16'h0000, 16'hBEEF, 1'b0);
    repeat (3) @(negedge CLK);
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
